multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle RV32 subset datapath
// (lw, sw, R-type add/sub/and/or, addi, beq) with a retired-instruction counter.
// Build macro ILLEGAL_TRAP_EN: unknown opcode/funct traps to a sticky HALT state
// and raises illegal; without it, unknown instructions retire as a PC+4 NOP.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic        PCSource,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [3:0]  state,
  output logic [31:0] instret,
  output logic        illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    LW_WB    = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    BR_NT    = 4'd9,
    NOP_INC  = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t cur_state;
  logic   is_lw, is_sw, is_rtype, is_addi, is_beq;
  logic   retire;

  assign state = cur_state;

  // Instruction class decode; R-type and addi are only legal for the funct codes the ALU supports
  always_comb begin
    is_lw    = (opcode == OP_LOAD);
    is_sw    = (opcode == OP_STORE);
    is_beq   = (opcode == OP_BRANCH);
    is_rtype = (opcode == OP_R) &&
               ((funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110));
    is_addi  = (opcode == OP_IMM) && (funct3 == 3'b000);
  end

  // An instruction retires on the edge that leaves its final state
  always_comb begin
    case (cur_state)
      LW_WB, MEM_WR, ALU_WB, BR_NT, NOP_INC: retire = 1'b1;
      BRANCH:                                retire = zero;
      default:                               retire = 1'b0;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // State sequencing, retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= FETCH;
      instret   <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      if (retire) instret <= instret + 32'd1;
      case (cur_state)
        FETCH:    cur_state <= DECODE;
        DECODE: begin
          if (is_lw || is_sw)            cur_state <= MEM_ADDR;
          else if (is_rtype || is_addi)  cur_state <= EXEC;
          else if (is_beq)               cur_state <= BRANCH;
          else begin
`ifdef ILLEGAL_TRAP_EN
            cur_state <= HALT;
            illegal_q <= 1'b1;
`else
            cur_state <= NOP_INC;
`endif
          end
        end
        MEM_ADDR: cur_state <= is_sw ? MEM_WR : MEM_RD;
        MEM_RD:   cur_state <= LW_WB;
        EXEC:     cur_state <= ALU_WB;
        BRANCH:   cur_state <= zero ? FETCH : BR_NT;
        HALT:     cur_state <= HALT;
        default:  cur_state <= FETCH;
      endcase
    end
  end

  // Moore control decode (PCWrite in BRANCH follows zero); reset forces everything low
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    PCSource   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (cur_state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
      end
      DECODE:   ALUSrcB = 2'b10;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      LW_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        ALUSrcB  = 2'b01;
        PCWrite  = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (opcode == OP_IMM) ? 2'b10 : 2'b00;
        if (opcode == OP_R) begin
          case (funct3)
            3'b000:  ALUControl = funct7_5 ? ALU_SUB : ALU_ADD;
            3'b111:  ALUControl = ALU_AND;
            3'b110:  ALUControl = ALU_OR;
            default: ALUControl = ALU_ADD;
          endcase
        end
      end
      ALU_WB:   RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSource   = 1'b1;
        PCWrite    = zero;
      end
      BR_NT, NOP_INC: begin
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      HALT:     ALUControl = '0;
      default: ;
    endcase
    if (!reset) begin
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      PCSource   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model for multicycle_control.
// Each instruction is expanded into its expected state walk; the control word
// for every step comes from a per-state table and the mnemonic being executed.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, PCSource, RegWrite;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [3:0]  state;
  logic [31:0] instret;
  logic        illegal;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
    .RegWrite(RegWrite), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .state(state),
    .instret(instret), .illegal(illegal)
  );

  typedef enum int {M_ADD, M_SUB, M_AND, M_OR, M_ADDI, M_LW, M_SW, M_BEQ, M_ILL} mn_t;

  typedef struct packed {
    logic       pcw, iord, mrd, mwr, irw, m2r, srca, pcsrc, rw;
    logic [1:0] srcb;
    logic [3:0] alu;
  } ctrl_t;

  ctrl_t dut_ctrl;
  assign dut_ctrl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                     PCSource, RegWrite, ALUSrcB, ALUControl};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_instret = '0;

  logic [3:0]  obs_state   [0:7];
  ctrl_t       obs_ctrl    [0:7];
  logic [31:0] obs_instret [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_for(mn_t m);
    case (m)
      M_SUB:   return 4'b0110;
      M_AND:   return 4'b0000;
      M_OR:    return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic ctrl_t exp_ctrl(int st, mn_t m, logic z);
    ctrl_t c;
    c = '0;
    c.alu = 4'b0010;
    case (st)
      0:  begin c.mrd = 1'b1; c.irw = 1'b1; end
      1:  c.srcb = 2'b10;
      2:  begin c.srca = 1'b1; c.srcb = 2'b10; end
      3:  begin c.mrd = 1'b1; c.iord = 1'b1; c.srcb = 2'b01; c.pcw = 1'b1; end
      4:  begin c.rw = 1'b1; c.m2r = 1'b1; end
      5:  begin c.mwr = 1'b1; c.iord = 1'b1; c.srcb = 2'b01; c.pcw = 1'b1; end
      6:  begin c.srca = 1'b1; c.srcb = (m == M_ADDI) ? 2'b10 : 2'b00; c.alu = alu_for(m); end
      7:  c.rw = 1'b1;
      8:  begin c.srca = 1'b1; c.alu = 4'b0110; c.pcsrc = 1'b1; c.pcw = z; end
      9, 10: begin c.srcb = 2'b01; c.pcw = 1'b1; end
      11: c.alu = 4'b0000;
      default: ;
    endcase
    return c;
  endfunction

  // Pick an encoding for a mnemonic; M_ILL draws from every kind of unsupported encoding
  task automatic pick(input mn_t m, output logic [6:0] op, output logic [2:0] f3, output logic f7);
    f7 = 1'($urandom_range(0, 1));
    f3 = 3'($urandom_range(0, 7));
    case (m)
      M_ADD:  begin op = 7'b0110011; f3 = 3'b000; f7 = 1'b0; end
      M_SUB:  begin op = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
      M_AND:  begin op = 7'b0110011; f3 = 3'b111; end
      M_OR:   begin op = 7'b0110011; f3 = 3'b110; end
      M_ADDI: begin op = 7'b0010011; f3 = 3'b000; end
      M_LW:   op = 7'b0000011;
      M_SW:   op = 7'b0100011;
      M_BEQ:  op = 7'b1100011;
      default: begin
        case ($urandom_range(0, 2))
          0: begin
            do op = 7'($urandom_range(0, 127));
            while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                   op == 7'b0010011 || op == 7'b1100011);
          end
          1: begin op = 7'b0110011; f3 = 3'($urandom_range(1, 5)); end
          default: begin op = 7'b0010011; f3 = 3'($urandom_range(1, 7)); end
        endcase
      end
    endcase
  endtask

  // Asynchronous reset mid-cycle, then release after a clock edge so FETCH runs next
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_state"},   {28'd0, state}, 32'd0);
    check({tag, "_ctrl"},    {17'd0, dut_ctrl}, 32'd0);
    check({tag, "_instret"}, instret, 32'd0);
    check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    exp_instret = '0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Run one instruction from FETCH; abort_at >= 0 pulses reset after that step's check
  task automatic run_instr(input mn_t m, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int abort_at);
    int  seq[$];
    int  n;
    logic exp_ill;
    seq = {0, 1};
    case (m)
      M_LW:   seq = {seq, 2, 3, 4};
      M_SW:   seq = {seq, 2, 5};
      M_BEQ:  begin seq.push_back(8); if (!z) seq.push_back(9); end
`ifdef ILLEGAL_TRAP_EN
      M_ILL:  seq.push_back(11);
`else
      M_ILL:  seq.push_back(10);
`endif
      default: seq = {seq, 6, 7};
    endcase
    n = seq.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
      end
      #1;
      exp_ill = (seq[k] == 11);
      check("state",   {28'd0, state}, 32'(seq[k]));
      check("ctrl",    {17'd0, dut_ctrl}, {17'd0, exp_ctrl(seq[k], m, z)});
      check("instret", instret, exp_instret);
      check("illegal", {31'd0, illegal}, {31'd0, exp_ill});
      obs_state[k]   = state;
      obs_ctrl[k]    = dut_ctrl;
      obs_instret[k] = instret;
      if (k == abort_at) begin
        do_reset("abort");
        return;
      end
      if (k == n - 1 && seq[k] != 11) exp_instret = exp_instret + 32'd1;
    end
`ifdef ILLEGAL_TRAP_EN
    if (m == M_ILL) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        zero = 1'($urandom_range(0, 1));
        #1;
        check("halt_state",   {28'd0, state}, 32'd11);
        check("halt_illegal", {31'd0, illegal}, 32'd1);
        check("halt_ctrl",    {17'd0, dut_ctrl}, 32'd0);
        check("halt_instret", instret, exp_instret);
      end
      do_reset("halt_exit");
    end
`endif
  endtask

  logic [31:0] iw;
  mn_t         rm;
  logic [6:0]  rop;
  logic [2:0]  rf3;
  logic        rf7, rz;

  initial begin
    reset = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0;
    #2;
    check("por_state",   {28'd0, state}, 32'd0);
    check("por_ctrl",    {17'd0, dut_ctrl}, 32'd0);
    check("por_instret", instret, 32'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;

    // addi x3,x0,20
    iw = 32'h01400193;
    run_instr(M_ADDI, iw[6:0], iw[14:12], iw[30], 1'b0, -1);
    check("addi_s0", {28'd0, obs_state[0]}, 32'd0);
    check("addi_s1", {28'd0, obs_state[1]}, 32'd1);
    check("addi_s2", {28'd0, obs_state[2]}, 32'd6);
    check("addi_s3", {28'd0, obs_state[3]}, 32'd7);
    check("addi_alu",  {28'd0, obs_ctrl[2].alu}, 32'h2);
    check("addi_srcb", {30'd0, obs_ctrl[2].srcb}, 32'h2);
    check("addi_rw",   {31'd0, obs_ctrl[3].rw}, 32'd1);
    check("addi_ir0",  obs_instret[3], 32'd0);

    // lw x8,120(x3)
    iw = 32'h0781A403;
    run_instr(M_LW, iw[6:0], iw[14:12], iw[30], 1'b0, -1);
    check("lw_ir1",  obs_instret[0], 32'd1);
    check("lw_s4",   {28'd0, obs_state[4]}, 32'd4);
    check("lw_iord", {31'd0, obs_ctrl[3].iord}, 32'd1);
    check("lw_m2r",  {31'd0, obs_ctrl[4].m2r}, 32'd1);
    check("lw_rw",   {31'd0, obs_ctrl[4].rw}, 32'd1);
    for (int k = 0; k < 5; k++)
      check("lw_pcw", {31'd0, obs_ctrl[k].pcw}, (k == 3) ? 32'd1 : 32'd0);

    // beq taken / not taken
    run_instr(M_BEQ, 7'b1100011, 3'b000, 1'b0, 1'b1, -1);
    check("beqt_s2",   {28'd0, obs_state[2]}, 32'd8);
    check("beqt_pcw",  {31'd0, obs_ctrl[2].pcw}, 32'd1);
    check("beqt_psrc", {31'd0, obs_ctrl[2].pcsrc}, 32'd1);
    run_instr(M_BEQ, 7'b1100011, 3'b000, 1'b0, 1'b0, -1);
    check("beqn_ir",   obs_instret[0], 32'd3);
    check("beqn_pcw",  {31'd0, obs_ctrl[2].pcw}, 32'd0);
    check("beqn_s3",   {28'd0, obs_state[3]}, 32'd9);
    check("beqn_psrc", {31'd0, obs_ctrl[3].pcsrc}, 32'd0);

    // sub / and / or ALU decode
    run_instr(M_SUB, 7'b0110011, 3'b000, 1'b1, 1'b0, -1);
    check("sub_alu", {28'd0, obs_ctrl[2].alu}, 32'h6);
    run_instr(M_AND, 7'b0110011, 3'b111, 1'b0, 1'b0, -1);
    check("and_alu", {28'd0, obs_ctrl[2].alu}, 32'h0);
    run_instr(M_OR, 7'b0110011, 3'b110, 1'b0, 1'b0, -1);
    check("or_alu",  {28'd0, obs_ctrl[2].alu}, 32'h1);

    // opcode 0x7F
    run_instr(M_ILL, 7'h7F, 3'b000, 1'b0, 1'b0, -1);
`ifdef ILLEGAL_TRAP_EN
    check("ill_s2", {28'd0, obs_state[2]}, 32'd11);
`else
    check("ill_s2", {28'd0, obs_state[2]}, 32'd10);
    run_instr(M_ADD, 7'b0110011, 3'b000, 1'b0, 1'b0, -1);
    check("ill_retired", obs_instret[0], 32'd8);
`endif

    // reset asserted while in MEM_RD
    run_instr(M_LW, 7'b0000011, 3'b010, 1'b0, 1'b0, 3);
    check("rst_memrd_seen", {28'd0, obs_state[3]}, 32'd3);
    run_instr(M_ADDI, 7'b0010011, 3'b000, 1'b0, 1'b0, -1);
    check("post_rst_ir", obs_instret[0], 32'd0);

    // randomized instruction stream with occasional aborts
    for (int i = 0; i < 400; i++) begin
      rm = mn_t'($urandom_range(0, 8));
      pick(rm, rop, rf3, rf7);
      rz = 1'($urandom_range(0, 1));
      run_instr(rm, rop, rf3, rf7, rz,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
